// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encoding and burst defaults for the SDRAM write path.
package sdram_pkg;
    typedef enum logic [1:0] {BST_IDLE, BST_REQ, BST_DATA} burster_state_e;
    localparam int SDRAM_BURST_LEN = 4;
endpackage

// File: rtl/sdram_wr_burster.sv
// sdram_wr_burster: drains an FWFT write FIFO into fixed-length SDRAM write bursts,
// padding short bursts with masked beats when flushing.
module sdram_wr_burster
    import sdram_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int FifoDepth = 8,
    parameter int BurstLen  = SDRAM_BURST_LEN,
    parameter int AddrWidth = 22
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_fifo_push,
    input  logic [DataWidth-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic                 i_addr_load,
    input  logic [AddrWidth-1:0] i_base_addr,
    input  logic                 i_flush,
    output logic                 o_req,
    output logic [AddrWidth-1:0] o_req_addr,
    input  logic                 i_req_ack,
    input  logic                 i_wr_data_req,
    output logic [DataWidth-1:0] o_wr_data,
    output logic                 o_wr_mask,
    output logic                 o_busy,
    output logic                 o_underrun
);
    localparam int LW = $clog2(FifoDepth + 1);
    localparam int PW = $clog2(BurstLen + 1);

    burster_state_e       state;
    logic [LW-1:0]        level;
    logic [PW-1:0]        beat;
    logic [PW-1:0]        pad_from;
    logic [AddrWidth-1:0] addr;
    logic                 strobe;
    logic                 real_beat;
    logic                 push_ok;
    logic                 start;

    assign strobe       = (state == BST_DATA) && i_wr_data_req;
    assign real_beat    = beat < pad_from;
    assign o_fifo_rd_en = strobe && real_beat && !i_fifo_empty;
    assign o_wr_data    = (strobe && real_beat) ? i_fifo_data : '0;
    assign o_wr_mask    = strobe && !real_beat;
    assign o_req_addr   = addr;
    // The FIFO silently drops a push when full, so the mirror must too.
    assign push_ok      = i_fifo_push && (level < LW'(FifoDepth));
    assign start        = (level >= LW'(BurstLen)) || (i_flush && level != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= BST_IDLE;
            level      <= '0;
            beat       <= '0;
            pad_from   <= '0;
            addr       <= '0;
            o_req      <= 1'b0;
            o_busy     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            level <= level + LW'(push_ok) - LW'(o_fifo_rd_en);
            if (strobe && real_beat && i_fifo_empty)
                o_underrun <= 1'b1;
            case (state)
                BST_IDLE: begin
                    if (i_addr_load)
                        addr <= i_base_addr;
                    if (start) begin
                        state    <= BST_REQ;
                        o_req    <= 1'b1;
                        o_busy   <= 1'b1;
                        pad_from <= (level >= LW'(BurstLen)) ? PW'(BurstLen) : PW'(level);
                    end
                end
                BST_REQ: begin
                    if (i_req_ack) begin
                        state <= BST_DATA;
                        o_req <= 1'b0;
                        beat  <= '0;
                    end
                end
                BST_DATA: begin
                    if (i_wr_data_req) begin
                        beat <= beat + 1'b1;
                        if (beat == PW'(BurstLen - 1)) begin
                            state  <= BST_IDLE;
                            o_busy <= 1'b0;
                            addr   <= addr + AddrWidth'(BurstLen);
                        end
                    end
                end
                default: begin
                    state  <= BST_IDLE;
                    o_req  <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_wr_burster.sv
// tb_sdram_wr_burster: randomized scenarios against a queue-based FIFO/burst model.
module tb_sdram_wr_burster;
    logic        clk = 1'b0;
    logic        i_rst_n, i_fifo_push, i_fifo_empty, i_addr_load, i_flush, i_req_ack, i_wr_data_req;
    logic [15:0] i_fifo_data, o_wr_data;
    logic [21:0] i_base_addr, o_req_addr;
    logic        o_fifo_rd_en, o_req, o_wr_mask, o_busy, o_underrun;

    logic [15:0] fq[$];
    logic [15:0] expd[$];
    logic [15:0] push_data = '0;
    logic [15:0] head = '0;
    int          cnt = 0;
    bit          force_empty = 0;
    logic        s_req, s_rd, s_mask, s_busy, s_under;
    logic [15:0] s_data;
    logic [21:0] s_addr, exp_addr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    assign i_fifo_data  = head;
    assign i_fifo_empty = force_empty || (cnt == 0);

    sdram_wr_burster dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_fifo_push(i_fifo_push), .i_fifo_data(i_fifo_data),
        .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en), .i_addr_load(i_addr_load),
        .i_base_addr(i_base_addr), .i_flush(i_flush), .o_req(o_req), .o_req_addr(o_req_addr),
        .i_req_ack(i_req_ack), .i_wr_data_req(i_wr_data_req), .o_wr_data(o_wr_data),
        .o_wr_mask(o_wr_mask), .o_busy(o_busy), .o_underrun(o_underrun)
    );

    // Samples outputs mid-cycle, then advances the FWFT FIFO model after the edge.
    task automatic tick();
        logic pop, push;
        logic [15:0] pd;
        @(negedge clk);
        s_req = o_req; s_addr = o_req_addr; s_rd = o_fifo_rd_en; s_data = o_wr_data;
        s_mask = o_wr_mask; s_busy = o_busy; s_under = o_underrun;
        pop = o_fifo_rd_en; push = i_fifo_push; pd = push_data;
        @(posedge clk);
        #1;
        if (push && fq.size() < 8) begin
            fq.push_back(pd);
            expd.push_back(pd);
        end
        if (pop && fq.size() > 0) void'(fq.pop_front());
        cnt  = fq.size();
        head = (cnt > 0) ? fq[0] : '0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            i_fifo_push = 1'b1;
            push_data   = 16'($urandom);
            tick();
        end
        i_fifo_push = 1'b0;
    endtask

    task automatic run_burst(input int empty_beat, input int push_n, output logic [21:0] a,
                             output logic [15:0] d[4], output logic m[4], output logic e[4],
                             output bit to);
        int n = 0;
        to = 0;
        a  = '0;
        for (int b = 0; b < 4; b++) begin
            d[b] = '0; m[b] = 1'b0; e[b] = 1'b0;
        end
        tick();
        while (!s_req && n < 200) begin
            tick();
            n++;
        end
        if (!s_req) begin
            to = 1;
            return;
        end
        a = s_addr;
        i_req_ack = 1'b1;
        tick();
        i_req_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            i_wr_data_req = 1'b1;
            force_empty   = (b == empty_beat);
            if (push_n > 0) begin
                i_fifo_push = 1'b1;
                push_data   = 16'($urandom);
                push_n--;
            end
            tick();
            d[b] = s_data; m[b] = s_mask; e[b] = s_rd;
            i_wr_data_req = 1'b0;
            force_empty   = 1'b0;
            i_fifo_push   = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_req, s_busy, s_rd, s_mask, s_under} !== 5'b0 || s_data !== '0 || s_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b busy=%b rd=%b mask=%b und=%b data=%h addr=%h exp all 0",
                     s_req, s_busy, s_rd, s_mask, s_under, s_data, s_addr);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_burst();
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to; logic [15:0] w[4];
        i_base_addr = 22'h100; i_addr_load = 1'b1;
        tick();
        i_addr_load = 1'b0;
        exp_addr = 22'h100;
        push_words(4);
        for (int i = 0; i < 4; i++) w[i] = expd[i];
        run_burst(-1, 0, a, d, m, e, to);
        checks++;
        if (to || a !== exp_addr) begin
            errors++;
            $display("FAIL full_addr got %h (timeout=%0d) exp %h", a, to, exp_addr);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (d[b] !== w[b] || m[b] !== 1'b0 || e[b] !== 1'b1) begin
                errors++;
                $display("FAIL full_beat%0d got d=%h m=%b rd=%b exp d=%h m=0 rd=1", b, d[b], m[b], e[b], w[b]);
            end
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_idle got busy=%b exp 0", s_busy);
        end
        repeat (4) void'(expd.pop_front());
        exp_addr = exp_addr + 22'd4;
    endtask

    task automatic test_flush();
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to; logic [15:0] w[4];
        bit quiet = 1;
        push_words(3);
        repeat (50) begin
            tick();
            if (s_req) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL partial_no_req got req seen exp none");
        end
        for (int i = 0; i < 3; i++) w[i] = expd[i];
        w[3] = '0;
        i_flush = 1'b1;
        run_burst(-1, 0, a, d, m, e, to);
        checks++;
        if (to || a !== exp_addr) begin
            errors++;
            $display("FAIL flush_addr got %h (timeout=%0d) exp %h", a, to, exp_addr);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (d[b] !== w[b] || m[b] !== (b == 3) || e[b] !== (b != 3)) begin
                errors++;
                $display("FAIL flush_beat%0d got d=%h m=%b rd=%b exp d=%h m=%0d rd=%0d",
                         b, d[b], m[b], e[b], w[b], b == 3, b != 3);
            end
        end
        repeat (3) void'(expd.pop_front());
        exp_addr = exp_addr + 22'd4;
        quiet = 1;
        repeat (20) begin
            tick();
            if (s_req || s_busy) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL flush_level_zero got req/busy with empty fifo exp idle");
        end
        i_flush = 1'b0;
    endtask

    task automatic two_bursts(input string tag, input int push_n);
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to; logic [15:0] w[4];
        bit quiet = 1;
        int pops = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) w[i] = expd[i];
            run_burst(-1, (k == 0) ? push_n : 0, a, d, m, e, to);
            checks++;
            if (to || a !== exp_addr) begin
                errors++;
                $display("FAIL %s_addr%0d got %h (timeout=%0d) exp %h", tag, k, a, to, exp_addr);
            end
            for (int b = 0; b < 4; b++) begin
                pops += int'(e[b]);
                checks++;
                if (d[b] !== w[b] || m[b] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_b%0d_beat%0d got d=%h m=%b exp d=%h m=0", tag, k, b, d[b], m[b], w[b]);
                end
            end
            repeat (4) void'(expd.pop_front());
            exp_addr = exp_addr + 22'd4;
        end
        checks++;
        if (pops != 8) begin
            errors++;
            $display("FAIL %s_pops got %0d exp 8", tag, pops);
        end
        i_flush = 1'b1;
        repeat (20) begin
            tick();
            if (s_req) quiet = 0;
        end
        i_flush = 1'b0;
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL %s_level_zero got req after drain exp none", tag);
        end
    endtask

    task automatic test_back_to_back();
        push_words(5);
        two_bursts("b2b", 3);
    endtask

    task automatic test_full_drop();
        push_words(10);
        two_bursts("drop", 0);
    endtask

    task automatic test_wrap();
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to;
        int n = 0;
        i_base_addr = 22'h3FFFFC; i_addr_load = 1'b1;
        tick();
        i_addr_load = 1'b0;
        exp_addr = 22'h3FFFFC;
        push_words(4);
        run_burst(-1, 0, a, d, m, e, to);
        repeat (4) void'(expd.pop_front());
        checks++;
        if (to || a !== 22'h3FFFFC) begin
            errors++;
            $display("FAIL wrap_first_addr got %h exp 3ffffc", a);
        end
        exp_addr = 22'h0;
        push_words(4);
        while (!s_req && n < 50) begin
            tick();
            n++;
        end
        i_base_addr = 22'h2AAAAA; i_addr_load = 1'b1;
        tick();
        i_addr_load = 1'b0;
        run_burst(-1, 0, a, d, m, e, to);
        repeat (4) void'(expd.pop_front());
        checks++;
        if (to || a !== exp_addr) begin
            errors++;
            $display("FAIL wrap_addr got %h (timeout=%0d) exp %h", a, to, exp_addr);
        end
        exp_addr = exp_addr + 22'd4;
    endtask

    task automatic test_underrun();
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to; logic [15:0] w[4];
        bit sticky = 1;
        push_words(4);
        checks++;
        if (s_under !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pre got %b exp 0", s_under);
        end
        for (int i = 0; i < 4; i++) w[i] = expd[i];
        run_burst(2, 0, a, d, m, e, to);
        checks++;
        if (to || d[0] !== w[0] || d[1] !== w[1] || d[3] !== w[2]) begin
            errors++;
            $display("FAIL underrun_data got %h %h %h exp %h %h %h", d[0], d[1], d[3], w[0], w[1], w[2]);
        end
        checks++;
        if ({e[0], e[1], e[2], e[3]} !== 4'b1101) begin
            errors++;
            $display("FAIL underrun_pops got %b%b%b%b exp 1101", e[0], e[1], e[2], e[3]);
        end
        checks++;
        if (s_under !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL underrun_flag got und=%b busy=%b exp und=1 busy=0", s_under, s_busy);
        end
        repeat (10) begin
            tick();
            if (s_under !== 1'b1) sticky = 0;
        end
        checks++;
        if (!sticky) begin
            errors++;
            $display("FAIL underrun_sticky got cleared exp held");
        end
        repeat (3) void'(expd.pop_front());
        exp_addr = exp_addr + 22'd4;
    endtask

    task automatic test_reset_mid();
        logic [21:0] a; logic [15:0] d[4]; logic m[4], e[4]; bit to; logic [15:0] w[4];
        bit quiet = 1;
        int n = 0;
        push_words(3);
        tick();
        while (!s_req && n < 50) begin
            tick();
            n++;
        end
        i_req_ack = 1'b1;
        tick();
        i_req_ack = 1'b0;
        i_wr_data_req = 1'b1;
        tick();
        i_rst_n = 1'b0;
        fq.delete(); expd.delete();
        cnt = 0; head = '0;
        tick();
        i_wr_data_req = 1'b0;
        checks++;
        if ({s_busy, s_req, s_rd, s_mask, s_under} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b req=%b rd=%b mask=%b und=%b exp all 0",
                     s_busy, s_req, s_rd, s_mask, s_under);
        end
        i_rst_n = 1'b1;
        tick();
        exp_addr = 22'h0;
        push_words(4);
        for (int i = 0; i < 4; i++) w[i] = expd[i];
        run_burst(-1, 0, a, d, m, e, to);
        checks++;
        if (to || a !== exp_addr || d[0] !== w[0] || d[3] !== w[3]) begin
            errors++;
            $display("FAIL reset_mid_after got addr=%h d0=%h d3=%h exp addr=%h d0=%h d3=%h",
                     a, d[0], d[3], exp_addr, w[0], w[3]);
        end
        repeat (4) void'(expd.pop_front());
        i_flush = 1'b1;
        repeat (20) begin
            tick();
            if (s_req) quiet = 0;
        end
        i_flush = 1'b0;
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_mid_level got req after drain exp none");
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_fifo_push = 1'b0; i_addr_load = 1'b0; i_flush = 1'b0;
        i_req_ack = 1'b0; i_wr_data_req = 1'b0; i_base_addr = '0; exp_addr = '0;
        test_reset();
        test_full_burst();
        test_flush();
        test_back_to_back();
        test_full_drop();
        test_wrap();
        test_underrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
